// File: rtl/servo_pos_ramp.sv
// Servo position ramp: maps 8-bit position commands to a PWM pulse width and
// slews the output duty toward that target by at most SLEW per 20 ms frame.
// Duty changes only at frame boundaries, and frame_start marks each boundary
// so the PWM stage can latch the new duty there.
module servo_pos_ramp #(
  parameter int FRAME_CYCLES = 500000,
  parameter int MIN_PULSE    = 25000,
  parameter int PULSE_LSB    = 98,
  parameter int SLEW         = 500,
  parameter int RESET_POS    = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_pos,
  output logic [18:0] duty,
  output logic        frame_start,
  output logic        busy,
  output logic        done
);

  localparam logic [18:0] RESET_DUTY = 19'(MIN_PULSE + RESET_POS * PULSE_LSB);
  localparam logic [18:0] LAST_CNT   = 19'(FRAME_CYCLES - 1);
  localparam logic [18:0] MIN19      = 19'(MIN_PULSE);
  localparam logic [18:0] LSB19      = 19'(PULSE_LSB);
  localparam logic [18:0] SLEW19     = 19'(SLEW);
  localparam logic [19:0] SLEW20     = 20'(SLEW);

  typedef enum logic [0:0] {IDLE, MOVING} state_t;

  state_t      state, state_next;
  logic [18:0] cnt;
  logic [18:0] target;
  logic [18:0] cmd_target;
  logic [18:0] target_next;
  logic [18:0] duty_next;
  logic [18:0] stepped;
  logic [19:0] duty20, target20, up20, diff20;
  logic        accept;
  logic        frame_end;
  logic        done_next;

  assign accept    = cmd_valid & cmd_ready;
  assign frame_end = (cnt == LAST_CNT);
  assign busy      = (state == MOVING);

  // The largest legal code keeps the product below 2^19, so 19 bits suffice.
  assign cmd_target = MIN19 + 19'(cmd_pos) * LSB19;

  // One slew step toward the held target; 20-bit math keeps the comparisons
  // free of wrap so the step saturates exactly at the target.
  always_comb begin
    duty20   = {1'b0, duty};
    target20 = {1'b0, target};
    up20     = duty20 + SLEW20;
    diff20   = duty20 - target20;
    stepped  = duty;
    if (target20 > duty20) begin
      stepped = (up20 >= target20) ? target : up20[18:0];
    end else if (target20 < duty20) begin
      stepped = (diff20 > SLEW20) ? (duty - SLEW19) : target;
    end
  end

  // Next duty/target: duty moves only at the frame end and always uses the
  // target held before this edge; a same-edge command lands in the next frame.
  always_comb begin
    duty_next   = duty;
    target_next = target;
    if (frame_end) duty_next = stepped;
    if (accept)    target_next = cmd_target;
  end

  // Move state: MOVING exactly while the output has not reached the target.
  // done fires when the target is reached by a move or by a command that
  // already equals the duty; an abandoned target never reaches done.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    if (target_next != duty_next) begin
      state_next = MOVING;
    end else begin
      state_next = IDLE;
      done_next  = accept || (state == MOVING);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Frame counter, strobes, duty/target registers and the ready flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      duty        <= RESET_DUTY;
      target      <= RESET_DUTY;
      cmd_ready   <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
    end else begin
      cnt         <= frame_end ? '0 : cnt + 19'd1;
      duty        <= duty_next;
      target      <= target_next;
      cmd_ready   <= 1'b1;
      frame_start <= frame_end;
      done        <= done_next;
    end
  end

endmodule

// File: tb/tb_servo_pos_ramp.sv
// Bench for servo_pos_ramp with a 100-cycle frame: a cycle-level reference
// model checked every cycle, plus directed scenarios with literal values.
module tb_servo_pos_ramp;

  localparam int FC   = 100;
  localparam int MINP = 25000;
  localparam int LSB  = 98;
  localparam int SLW  = 500;
  localparam int RPOS = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_pos = '0;
  logic        cmd_ready;
  logic [18:0] duty;
  logic        frame_start;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int max_duty = 0;

  servo_pos_ramp #(.FRAME_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_pos(cmd_pos), .duty(duty), .frame_start(frame_start),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pos2duty(input int p);
    return MINP + p * LSB;
  endfunction

  // Reference model: position in frame, pulse width and goal, in plain ints.
  int m_cnt, m_duty, m_target, m_nd, m_nt;
  bit m_ready, m_fs, m_busy, m_done, m_on, m_acc, m_end;

  initial begin
    m_on = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_cnt = 0; m_duty = pos2duty(RPOS); m_target = m_duty;
        m_ready = 0; m_fs = 0; m_busy = 0; m_done = 0;
      end else begin
        m_acc = cmd_valid && m_ready;
        m_end = (m_cnt == FC - 1);
        m_nd  = m_duty;
        if (m_end) begin
          if (m_target > m_duty)
            m_nd = (m_duty + SLW < m_target) ? m_duty + SLW : m_target;
          else if (m_target < m_duty)
            m_nd = (m_duty - SLW > m_target) ? m_duty - SLW : m_target;
        end
        m_nt     = m_acc ? pos2duty(int'(cmd_pos)) : m_target;
        m_done   = (m_nt == m_nd) && (m_acc || m_target != m_duty);
        m_busy   = (m_nt != m_nd);
        m_fs     = m_end;
        m_cnt    = (m_cnt + 1) % FC;
        m_duty   = m_nd;
        m_target = m_nt;
        m_ready  = 1;
      end
      m_on = 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_on) begin
        chk("duty", int'(duty), m_duty);
        chk("busy", int'(busy), int'(m_busy));
        chk("done", int'(done), int'(m_done));
        chk("frame_start", int'(frame_start), int'(m_fs));
        chk("cmd_ready", int'(cmd_ready), int'(m_ready));
        if (done) done_cnt++;
        if (int'(duty) > max_duty) max_duty = int'(duty);
      end
    end
  end

  // Present one command for a single cycle; returns on the negedge after accept.
  task automatic send(input int p);
    cmd_valid = 1'b1;
    cmd_pos   = 8'(p);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Advance to the next negedge showing frame_start, bounded.
  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 3 * FC);
    chk("fs_seen", int'(frame_start), 1);
  endtask

  int n, frames, d0;

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    chk("rst_duty", int'(duty), 37544);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", int'(cmd_ready), 1);
    n = 1;
    while (!frame_start && n < 3 * FC) begin
      @(negedge clk);
      n++;
    end
    chk("first_fs_gap", n, 100);
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < 3 * FC);
    chk("fs_period", n, 100);

    // Small move 128 -> 130
    send(130);
    chk("small_busy", int'(busy), 1);
    chk("small_duty_hold", int'(duty), 37544);
    wait_fs();
    chk("small_duty", int'(duty), 37740);
    chk("small_done", int'(done), 1);
    @(negedge clk);
    chk("small_done_off", int'(done), 0);
    chk("small_idle", int'(busy), 0);

    // Back to 37544, then full-scale up
    send(128);
    wait_fs();
    chk("back_duty", int'(duty), 37544);
    @(negedge clk);
    send(255);
    frames = 0;
    do begin
      wait_fs();
      frames++;
      if (frames == 1)  chk("up_f1", int'(duty), 38044);
      if (frames == 2)  chk("up_f2", int'(duty), 38544);
      if (frames == 24) chk("up_f24", int'(duty), 49544);
    end while (!done && frames < 30);
    chk("up_frames", frames, 25);
    chk("up_final", int'(duty), 49990);
    @(negedge clk);
    chk("max_duty_bound", int'(max_duty <= 49990), 1);

    // Down then retarget up
    d0 = done_cnt;
    send(0);
    for (int i = 1; i <= 3; i++) begin
      wait_fs();
      chk("down_step", int'(duty), 49990 - 500 * i);
    end
    send(255);
    for (int i = 1; i <= 3; i++) begin
      wait_fs();
      chk("retarget_step", int'(duty), 48490 + 500 * i);
    end
    chk("retarget_done", int'(done), 1);
    @(negedge clk);
    chk("single_done", done_cnt - d0, 1);

    // Accept on the update edge (counter 99): update uses the old target
    send(0);
    repeat (97) @(negedge clk);
    send(255);
    chk("same_edge_fs", int'(frame_start), 1);
    chk("same_edge_duty", int'(duty), 49490);
    chk("same_edge_busy", int'(busy), 1);
    wait_fs();
    chk("same_edge_next", int'(duty), 49990);
    chk("same_edge_done", int'(done), 1);

    // Null command
    repeat (5) @(negedge clk);
    send(255);
    chk("null_done", int'(done), 1);
    chk("null_busy", int'(busy), 0);
    chk("null_duty", int'(duty), 49990);
    @(negedge clk);
    chk("null_done_off", int'(done), 0);

    // Reset during an upward ramp
    send(0);
    wait_fs();
    wait_fs();
    chk("pre_up_duty", int'(duty), 48990);
    send(255);
    wait_fs();
    chk("mid_up_duty", int'(duty), 49490);
    repeat (10) @(negedge clk);
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_duty", int'(duty), 37544);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ready", int'(cmd_ready), 0);
    rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < 3 * FC);
    chk("midrst_fs_gap", n, 100);
    chk("midrst_duty_after", int'(duty), 37544);
    chk("midrst_no_done", done_cnt - d0, 0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
